// File: rtl/cmd_fifo_arbiter_if.sv
// Requester, grant and shared-FIFO write signals of cmd_fifo_arbiter.
// req_lock is present only when ARB_LOCK_EN is defined.
interface cmd_fifo_arbiter_if #(
   parameter int WIDTH    = 8,
   parameter int DEPTH_P2 = 6
);
   logic [3:0]         req;
   logic [4*WIDTH-1:0] req_data;
`ifdef ARB_LOCK_EN
   logic [3:0]         req_lock;
`endif
   logic [3:0]         gnt;
   logic [DEPTH_P2:0]  fifo_fillcount;
   logic               fifo_put;
   logic [WIDTH-1:0]   fifo_data_in;
   logic               stall;

   // master is the arbiter, which owns the grant and FIFO write side
   modport master (
      input  req,
      input  req_data,
`ifdef ARB_LOCK_EN
      input  req_lock,
`endif
      input  fifo_fillcount,
      output gnt,
      output fifo_put,
      output fifo_data_in,
      output stall
   );

   modport slave (
      output req,
      output req_data,
`ifdef ARB_LOCK_EN
      output req_lock,
`endif
      output fifo_fillcount,
      input  gnt,
      input  fifo_put,
      input  fifo_data_in,
      input  stall
   );
endinterface

// File: rtl/cmd_fifo_arbiter.sv
// Four-way round-robin arbiter writing one command word per cycle into a shared FIFO.
// Define ARB_LOCK_EN to add per-requester burst locking (up to 4 grants per burst).
module cmd_fifo_arbiter #(
   parameter int WIDTH    = 8,
   parameter int DEPTH_P2 = 6
) (
   input logic                clk,
   input logic                reset_n,
   cmd_fifo_arbiter_if.master bus
);
   localparam int CNT_W = DEPTH_P2 + 2;
   localparam logic [CNT_W-1:0] CAP = CNT_W'(2 ** DEPTH_P2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      STALL = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic             fifoPut_q, fifoPut_d;
   logic [WIDTH-1:0] fifoData_q, fifoData_d;
   logic             stall_q, stall_d;
   logic [1:0]       lastWinner_q, lastWinner_d;
   logic [1:0]       rrWinner;
   logic             rrFound;
   logic [1:0]       winner;
   logic             reqAny;
   logic             spaceAvail;
`ifdef ARB_LOCK_EN
   logic             lockActive_q, lockActive_d;
   logic [2:0]       lockCount_q, lockCount_d;
   logic             lockHold;
`endif

   // The put issued this cycle lands at the next edge, so count it as occupied
   assign spaceAvail = ({1'b0, bus.fifo_fillcount} + CNT_W'(fifoPut_q)) < CAP;
   assign reqAny     = |bus.req;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, ISSUE, STALL: begin
            if (!reqAny) begin
               state_d = IDLE;
            end else if (spaceAvail) begin
               state_d = ISSUE;
            end else begin
               state_d = STALL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rrWinner = lastWinner_q;
      rrFound  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (!rrFound && bus.req[lastWinner_q + 2'(k)]) begin
            rrWinner = lastWinner_q + 2'(k);
            rrFound  = 1'b1;
         end
      end
   end

   always_comb begin
      winner       = rrWinner;
      gnt_d        = '0;
      fifoPut_d    = 1'b0;
      fifoData_d   = fifoData_q;
      stall_d      = (state_d == STALL);
      lastWinner_d = lastWinner_q;
`ifdef ARB_LOCK_EN
      lockActive_d = lockActive_q;
      lockCount_d  = lockCount_q;
      lockHold     = lockActive_q && bus.req[lastWinner_q] && bus.req_lock[lastWinner_q];
      if (lockHold) begin
         winner = lastWinner_q;
      end
`endif
      if (state_d == ISSUE) begin
         gnt_d[winner] = 1'b1;
         fifoPut_d     = 1'b1;
         fifoData_d    = bus.req_data[winner*WIDTH +: WIDTH];
         lastWinner_d  = winner;
`ifdef ARB_LOCK_EN
         // A burst ends on its 4th grant; the next search starts after the owner
         if (lockHold) begin
            if (lockCount_q == 3'd3) begin
               lockActive_d = 1'b0;
               lockCount_d  = 3'd0;
            end else begin
               lockCount_d = lockCount_q + 3'd1;
            end
         end else if (bus.req_lock[winner]) begin
            lockActive_d = 1'b1;
            lockCount_d  = 3'd1;
         end else begin
            lockActive_d = 1'b0;
            lockCount_d  = 3'd0;
         end
      end else if (!lockHold) begin
         lockActive_d = 1'b0;
         lockCount_d  = 3'd0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         fifoPut_q    <= 1'b0;
         fifoData_q   <= '0;
         stall_q      <= 1'b0;
         lastWinner_q <= 2'd3;
`ifdef ARB_LOCK_EN
         lockActive_q <= 1'b0;
         lockCount_q  <= 3'd0;
`endif
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         fifoPut_q    <= fifoPut_d;
         fifoData_q   <= fifoData_d;
         stall_q      <= stall_d;
         lastWinner_q <= lastWinner_d;
`ifdef ARB_LOCK_EN
         lockActive_q <= lockActive_d;
         lockCount_q  <= lockCount_d;
`endif
      end
   end

   assign bus.gnt          = gnt_q;
   assign bus.fifo_put     = fifoPut_q;
   assign bus.fifo_data_in = fifoData_q;
   assign bus.stall        = stall_q;
endmodule

// File: doc/cmd_fifo_arbiter.md
CMD_FIFO_ARBITER -- requirements
Module: cmd_fifo_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the command word width in bits.
REQ-002 SHALL have parameter DEPTH_P2, default 6, giving log2 of the attached FIFO capacity (CAP = 2**DEPTH_P2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  one clock domain; reset is synchronous and active-low.
REQ-005 req  input  4  per-requester request; bit i is requester i.
REQ-006 req_data  input  4*WIDTH  command words; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 req_lock  input  4  per-requester burst lock; present only when ARB_LOCK_EN is defined.
REQ-008 gnt  output  4  one-hot grant pulse; gnt[i]=1 means requester i's word is written this cycle.
REQ-009 fifo_fillcount  input  DEPTH_P2+1  occupancy reported by the shared FIFO.
REQ-010 fifo_put  output  1  write strobe to the FIFO.
REQ-011 fifo_data_in  output  WIDTH  write data to the FIFO.
REQ-012 stall  output  1  high while any req is pending and no FIFO space is available.

Function
REQ-013 Outputs gnt, fifo_put, fifo_data_in and stall SHALL be registered.
REQ-014 gnt SHALL be zero or one-hot, and fifo_put SHALL equal |gnt in every cycle.
REQ-015 Space SHALL be (fifo_fillcount + fifo_put) < CAP, computed in DEPTH_P2+2 bits; a FIFO full flag is not used.
REQ-016 The FSM SHALL have states IDLE, ISSUE and STALL, encoded in 2 bits.
REQ-017 From IDLE or ISSUE: if req!=0 and space, go to ISSUE and grant the winner at the next edge.
REQ-018 From IDLE or ISSUE: if req!=0 and no space, go to STALL.
REQ-019 From IDLE or ISSUE: if req==0, go to IDLE.
REQ-020 From STALL: go to ISSUE when space and req!=0, and to IDLE when req==0.
REQ-021 Latency: req[i] sampled high at edge k (and winning) -> gnt[i], fifo_put and fifo_data_in=req_data[i] valid in the cycle after edge k.
REQ-022 Throughput: one grant per cycle sustained while space exists.
REQ-023 Round-robin: the search starts at last_winner+1 mod 4, and last_winner updates only on a grant.
REQ-024 A requester SHALL update req/req_data in the cycle gnt[i] is high; an unchanged req counts as a new request.
REQ-025 A req dropped before it is granted SHALL be ignored, with no state corruption.
REQ-026 stall SHALL be high exactly in STALL and low otherwise.
REQ-027 Boundary: with fillcount=CAP-1 and fifo_put=1, no grant is issued that edge, so the FIFO never overflows.
REQ-028 Boundary: fillcount=CAP combined with a downstream get SHALL resume grants the cycle after the fillcount decrement is seen.

Reset
REQ-029 When reset_n=0 at an edge, SHALL set state=IDLE, gnt=0, fifo_put=0, fifo_data_in=0, stall=0, last_winner=3 (so requester 0 wins first), and clear the lock state.
REQ-030 Reset asserted mid-burst or mid-stall SHALL take effect at that edge, with no put issued in the following cycle.

Configuration
REQ-031 Macro ARB_LOCK_EN SHALL compile the lock feature in.
REQ-032 With ARB_LOCK_EN defined: if the winner has req_lock high when granted, it SHALL keep priority for consecutive grants while req and req_lock stay high, up to 4 grants per burst.
REQ-033 With ARB_LOCK_EN defined: after the 4th grant, or when lock drops, round-robin SHALL resume from winner+1.
REQ-034 With ARB_LOCK_EN defined: a burst interrupted by STALL SHALL stay locked and continue when space returns.
REQ-035 Without ARB_LOCK_EN: the req_lock port SHALL be absent and arbitration SHALL be pure round-robin.

Verification
REQ-036 Scenario: reset_n=0 for 2 cycles with req=4'hF -> gnt=0, fifo_put=0, stall=0; after release, first gnt=4'b0001.
REQ-037 Scenario: req=4'hF held, fillcount=0, data i=8'hA0+i -> gnt sequence 1,2,4,8,1 on consecutive cycles; fifo_data_in sequence A0,A1,A2,A3,A0.
REQ-038 Scenario: DEPTH_P2=2, fillcount=3, req=4'b0010 -> one grant, then stall=1 with no put at fillcount=4; fillcount drops to 3 -> next cycle gnt=4'b0010.
REQ-039 Scenario: req=4'b0101, requester 0 drops req before grant -> only requester 2 is granted, and gnt is never 4'b0001.
REQ-040 Scenario (ARB_LOCK_EN): req=4'hF, req_lock=4'b0001 -> gnt=1,1,1,1,2,4,8; with lock dropped after 2 grants -> 1,1,2.
REQ-041 Scenario: reset_n=0 asserted during a locked burst with fillcount=CAP -> state IDLE, stall=0 next cycle, no write issued.
